multicycle_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit for the multicycle core, parametrised in operand width and bits retired per cycle. Sits beside the ALU in the execute step. The control unit pulses `start` with `funct3` and the A/B register values, then holds the EX state until `done`; `result` then feeds the ALUOut register. Replaces the single-cycle-only ALU path for M-extension ops. Provides signed/unsigned handling, RISC-V divide-by-zero and overflow semantics, and abort.

---
 rtl/multicycle_muldiv_pkg.sv | 32 +++
 rtl/multicycle_muldiv_step.sv | 32 +++
 rtl/multicycle_muldiv.sv | 139 +++++++++++++
 tb/tb_multicycle_muldiv.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encodings, the FSM state codes and the operand signedness helpers.
package multicycle_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    localparam int MULDIV_DIV_BIT = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // MUL only needs the low half of the product, which is sign-agnostic
    function automatic logic a_is_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/multicycle_muldiv_step.sv
// One combinational iteration step: shift-add for multiply, restoring compare-subtract for divide.
// The accumulator packs {partial product | remainder, multiplier | dividend bits still to consume}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        partial = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        diff    = partial - {1'b0, operand};
        if (is_div) begin
            // A borrow means the divisor did not fit: keep the shifted remainder, quotient bit 0
            if (diff[WIDTH]) begin
                acc_out = {partial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/multicycle_muldiv.sv
// Iterative RV32M multiply/divide unit for the multicycle core's execute step.
// Works on operand magnitudes, then restores signs in a single FIXUP cycle.
module multicycle_muldiv
    import multicycle_muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int STEPS = WIDTH / UNROLL;
    localparam int CW    = ($clog2(STEPS) > 0) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0]    COUNT_INIT = CW'(STEPS - 1);
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state, state_next;
    logic [CW-1:0]      count;
    muldiv_op_t         op_q;
    logic               is_div_q;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   operand_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_chain [UNROLL+1];

    muldiv_op_t         op_in;
    logic               sign_a, sign_b, is_div_in, special;
    logic [WIDTH-1:0]   mag_a, mag_b, special_result;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot, rem, fixup_result;

    // Accept-time decode: magnitudes, signs and the divide corner cases that skip CALC
    always_comb begin
        op_in          = muldiv_op_t'(funct3);
        sign_a         = a_is_signed(op_in) && op_a[WIDTH-1];
        sign_b         = b_is_signed(op_in) && op_b[WIDTH-1];
        mag_a          = sign_a ? -op_a : op_a;
        mag_b          = sign_b ? -op_b : op_b;
        is_div_in      = funct3[MULDIV_DIV_BIT];
        special        = 1'b0;
        special_result = '0;
        if (is_div_in && (op_b == '0)) begin
            special        = 1'b1;
            special_result = funct3[1] ? op_a : '1;
        end else if (is_div_in && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1)) begin
            special        = 1'b1;
            special_result = funct3[1] ? '0 : op_a;
        end
    end

    assign acc_chain[0] = acc;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_div  (is_div_q),
            .acc_in  (acc_chain[i]),
            .operand (operand_q),
            .acc_out (acc_chain[i+1])
        );
    end

    always_comb begin
        product = neg_res ? -acc : acc;
        quot    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                       fixup_result = product[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixup_result = product[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fixup_result = quot;
            default:                      fixup_result = rem;
        endcase
    end

    always_comb begin
        state_next = state;
        if (kill) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_next = special ? ST_DONE : ST_CALC;
                ST_CALC:  if (count == '0) state_next = ST_FIXUP;
                ST_FIXUP: state_next = ST_DONE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // busy/done are registered from the next state so outputs never depend combinationally on inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            op_q      <= OP_MUL;
            is_div_q  <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            operand_q <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_CALC) || (state_next == ST_FIXUP);
            done  <= (state_next == ST_DONE);
            if (!kill) begin
                if ((state == ST_IDLE) && start) begin
                    op_q      <= op_in;
                    is_div_q  <= is_div_in;
                    neg_res   <= sign_a ^ sign_b;
                    neg_rem   <= sign_a;
                    operand_q <= mag_b;
                    acc       <= {{WIDTH{1'b0}}, mag_a};
                    count     <= COUNT_INIT;
                    if (special) begin
                        result <= special_result;
                    end
                end else if (state == ST_CALC) begin
                    acc   <= acc_chain[UNROLL];
                    count <= count - 1'b1;
                end else if (state == ST_FIXUP) begin
                    result <= fixup_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_multicycle_muldiv.sv
// Scoreboard bench for multicycle_muldiv: directed RV32M vectors on a UNROLL=1 and a UNROLL=4 instance.
// Stimulus pushes expected result/latency/busy-length; a negedge monitor pops and compares on each done.
module tb_multicycle_muldiv;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
        int          busy_len;
        int          issue_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_s  [2];
    logic [2:0]  funct3_s [2];
    logic [31:0] op_a_s   [2];
    logic [31:0] op_b_s   [2];
    logic        kill_s   [2];
    logic        busy_s   [2];
    logic        done_s   [2];
    logic [31:0] result_s [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   run [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_muldiv #(.WIDTH(32), .UNROLL(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start_s[0]), .funct3(funct3_s[0]),
        .op_a(op_a_s[0]), .op_b(op_b_s[0]), .kill(kill_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .result(result_s[0])
    );

    multicycle_muldiv #(.WIDTH(32), .UNROLL(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_s[1]), .funct3(funct3_s[1]),
        .op_a(op_a_s[1]), .op_b(op_b_s[1]), .kill(kill_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .result(result_s[1])
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    // Drives one accept cycle at the current negedge; operands are scrambled afterwards
    task automatic apply_stimulus(input int sel, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] exp_res,
                                  input int lat, input int busy_len, input string name, input bit push);
        exp_t e;
        start_s[sel]  = 1'b1;
        funct3_s[sel] = f;
        op_a_s[sel]   = a;
        op_b_s[sel]   = b;
        if (push) begin
            e.name = name; e.res = exp_res; e.lat = lat; e.busy_len = busy_len; e.issue_cyc = cyc;
            if (sel == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(negedge clk);
        start_s[sel]  = 1'b0;
        funct3_s[sel] = 3'($urandom);
        op_a_s[sel]   = $urandom;
        op_b_s[sel]   = $urandom;
    endtask

    task automatic wait_drain(input int sel);
        int t = 0;
        while (qsize(sel) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (qsize(sel) != 0) begin
            checks++;
            $display("[TB] FAIL drain_timeout dut%0d: %0d responses outstanding, required 0", sel, qsize(sel));
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (busy_s[i] && done_s[i]) begin
                    checks++;
                    $display("[TB] FAIL busy_done_overlap dut%0d: busy=1 done=1, required not both high", i);
                end
                if (done_s[i]) begin
                    if (qsize(i) == 0) begin
                        checks++;
                        $display("[TB] FAIL spurious_done dut%0d: done=1 result=0x%08h, required no done", i, result_s[i]);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        check_output({e.name, "_result"}, result_s[i], e.res);
                        check_output({e.name, "_latency"}, 32'(cyc - e.issue_cyc), 32'(e.lat));
                        check_output({e.name, "_busy_cycles"}, 32'(run[i]), 32'(e.busy_len));
                    end
                end
                if (busy_s[i]) run[i] = run[i] + 1;
                else run[i] = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; funct3_s[i] = 3'b0; op_a_s[i] = '0; op_b_s[i] = '0; kill_s[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("reset_busy_dut%0d", i), {31'b0, busy_s[i]}, 32'd0);
            check_output($sformatf("reset_done_dut%0d", i), {31'b0, done_s[i]}, 32'd0);
            check_output($sformatf("reset_result_dut%0d", i), result_s[i], 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        apply_stimulus(0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33, "mul_7_m3", 1);       wait_drain(0);
        apply_stimulus(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 33, "mulh_min_min", 1);   wait_drain(0);
        apply_stimulus(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 33, "mulhu_max", 1);      wait_drain(0);
        apply_stimulus(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33, "mulhsu_m1_max", 1);  wait_drain(0);
        apply_stimulus(0, 3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34, 33, "mulh_m2_3", 1);      wait_drain(0);
        apply_stimulus(0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 33, "div_m7_2", 1);       wait_drain(0);
        apply_stimulus(0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 33, "rem_m7_2", 1);       wait_drain(0);
        apply_stimulus(0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0,  "divu_by0", 1);       wait_drain(0);
        apply_stimulus(0, 3'b110, 32'd5,        32'd0,        32'd5,        1,  0,  "rem_by0", 1);        wait_drain(0);
        apply_stimulus(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0,  "div_ovf", 1);        wait_drain(0);
        apply_stimulus(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0,  "rem_ovf", 1);        wait_drain(0);
        apply_stimulus(0, 3'b101, 32'd100,      32'd7,        32'd14,       34, 33, "divu_100_7", 1);     wait_drain(0);
        apply_stimulus(0, 3'b111, 32'd100,      32'd7,        32'd2,        34, 33, "remu_100_7", 1);     wait_drain(0);

        // Abort in the 10th CALC cycle; a fresh accept follows on the very next edge
        apply_stimulus(0, 3'b101, 32'd1000, 32'd3, 32'd0, 0, 0, "killed_divu", 0);
        repeat (9) @(negedge clk);
        kill_s[0] = 1'b1;
        @(negedge clk);
        kill_s[0] = 1'b0;
        check_output("kill_busy", {31'b0, busy_s[0]}, 32'd0);
        check_output("kill_result_kept", result_s[0], 32'd2);
        apply_stimulus(0, 3'b100, 32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 34, 33, "div_after_kill", 1);
        wait_drain(0);

        apply_stimulus(0, 3'b000, 32'd11, 32'd13, 32'd0, 0, 0, "reset_mul", 0);
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_output("midrun_reset_busy", {31'b0, busy_s[0]}, 32'd0);
        check_output("midrun_reset_done", {31'b0, done_s[0]}, 32'd0);
        check_output("midrun_reset_result", result_s[0], 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        apply_stimulus(1, 3'b000, 32'd123, 32'd456, 32'd56088, 10, 9, "unroll4_mul", 1);
        @(negedge clk);
        start_s[1] = 1'b1; funct3_s[1] = 3'b000; op_a_s[1] = 32'd2; op_b_s[1] = 32'd3;
        @(negedge clk);
        start_s[1] = 1'b0;
        wait_drain(1);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
